// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default iteration counter width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for the MDU: operand magnitudes on entry, and conditional
// negation of the product, or of the quotient and remainder, on exit.
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               a_neg,
    output logic               b_neg,
    input  logic               is_mul,
    input  logic               prod_neg,
    input  logic               quo_neg,
    input  logic               rem_neg,
    input  logic [2*WIDTH-1:0] raw,
    output logic [2*WIDTH-1:0] fixed
);

    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        fixed = raw;
        if (is_mul) begin
            if (prod_neg) fixed = -raw;
        end else begin
            if (rem_neg) fixed[2*WIDTH-1:WIDTH] = -raw[2*WIDTH-1:WIDTH];
            if (quo_neg) fixed[WIDTH-1:0]       = -raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional macro MDU_DIV_ZERO_FLAG_EN adds a sticky DivZero output.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MDU_DIV_ZERO_FLAG_EN
    ,
    output logic             DivZero
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi_q;  // partial product high / partial remainder
    logic [WIDTH-1:0]   acc_lo_q;  // multiplier bits / dividend-then-quotient
    logic               neg_q, rem_neg_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               start_ok, last, is_mul;
    logic [WIDTH-1:0]   ent_a_mag, ent_b_mag;
    logic               ent_a_neg, ent_b_neg;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] fixed;

    assign start_ok = Start && (state_q != StRun);
    assign last     = (cnt_q == CntW'(WIDTH - 1));
    assign is_mul   = (op_q == MDU_MULT) || (op_q == MDU_MULTU);

    // On divide-by-zero the remainder path restores |A|; re-applying sign(A)
    // returns A unchanged, so only the quotient correction is suppressed.
    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_signed (Op == MDU_MULT || Op == MDU_DIV),
        .a         (A),
        .b         (B),
        .a_mag     (ent_a_mag),
        .b_mag     (ent_b_mag),
        .a_neg     (ent_a_neg),
        .b_neg     (ent_b_neg),
        .is_mul    (is_mul),
        .prod_neg  (neg_q),
        .quo_neg   (neg_q & ~dz_q),
        .rem_neg   (rem_neg_q),
        .raw       ({nxt_hi, nxt_lo}),
        .fixed     (fixed)
    );

    always_comb begin
        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (is_mul) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (shifted >= {1'b0, opnd_q}) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = Start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            op_q      <= MDU_MULT;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != StRun) begin
                if (HiWrite) hi_q <= A;
                if (LoWrite) lo_q <= A;
            end
            if (start_ok) begin
                op_q      <= mdu_op_e'(Op);
                cnt_q     <= '0;
                opnd_q    <= Op[1] ? ent_b_mag : ent_a_mag;
                acc_hi_q  <= '0;
                acc_lo_q  <= Op[1] ? ent_a_mag : ent_b_mag;
                neg_q     <= ent_a_neg ^ ent_b_neg;
                rem_neg_q <= ent_a_neg;
                dz_q      <= Op[1] && (B == '0);
            end else if (state_q == StRun) begin
                cnt_q    <= cnt_q + 1'b1;
                acc_hi_q <= nxt_hi;
                acc_lo_q <= nxt_lo;
                if (last) begin
                    hi_q <= fixed[2*WIDTH-1:WIDTH];
                    lo_q <= dz_q ? '1 : fixed[WIDTH-1:0];
                end
            end
        end
    end

`ifdef MDU_DIV_ZERO_FLAG_EN
    logic div_zero_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_zero_q <= 1'b0;
        end else if (start_ok) begin
            div_zero_q <= 1'b0;
        end else if (state_q == StRun && last && dz_q) begin
            div_zero_q <= 1'b1;
        end
    end

    assign DivZero = div_zero_q;
`endif

    assign Busy = (state_q == StRun);
    assign Done = (state_q == StDone);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
